// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the memory-stage FSM state encoding.
package pipeline_pkg;

  localparam int WORD_W              = 32;
  localparam int REG_ADDR_W          = 5;
  localparam int DEFAULT_MEM_LATENCY = 0;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, synchronous write.
// Contents are deliberately not reset.
module data_memory
  import pipeline_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register with a configurable access latency.
// Optional misaligned-access trap (adds port wexc) enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mwreg,
  input  logic                  mm2reg,
  input  logic                  mwmem,
  input  logic [REG_ADDR_W-1:0] mdestReg,
  input  logic [WORD_W-1:0]     mr,
  input  logic [WORD_W-1:0]     mqb,
  output logic                  stall,
  output logic                  wwreg,
  output logic                  wm2reg,
  output logic [REG_ADDR_W-1:0] wdestReg,
  output logic [WORD_W-1:0]     wr,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  wexc,
`endif
  output logic [WORD_W-1:0]     wdo
);

  logic              access;
  logic              complete;
  logic              busy_stall;
  logic              misalign;
  logic              mem_we;
  logic [WORD_W-1:0] rdata;
  logic              unused_addr_bits;

  assign access = mm2reg | mwmem;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (mr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upper bits alias the array; low bits only matter to the trap.
  assign unused_addr_bits = ^{mr[WORD_W-1:ADDR_BITS+2], mr[1:0]};

  generate
    if (MEM_LATENCY == 0) begin : g_single_cycle
      assign complete   = 1'b1;
      assign busy_stall = 1'b0;
    end else begin : g_multi_cycle
      mem_state_t state_reg, state_next;
      logic [3:0] count_reg, count_next;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_reg <= MEM_IDLE;
          count_reg <= '0;
        end else begin
          state_reg <= state_next;
          count_reg <= count_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        busy_stall = 1'b0;
        complete   = 1'b1;
        case (state_reg)
          MEM_IDLE: begin
            if (access) begin
              busy_stall = 1'b1;
              complete   = 1'b0;
              count_next = 4'(MEM_LATENCY - 1);
              state_next = MEM_WAIT;
            end
          end
          MEM_WAIT: begin
            if (count_reg != 4'd0) begin
              busy_stall = 1'b1;
              complete   = 1'b0;
              count_next = count_reg - 4'd1;
            end else begin
              state_next = MEM_IDLE;
            end
          end
          default: state_next = MEM_IDLE;
        endcase
      end
    end
  endgenerate

  // Reset must drop stall immediately, even while the inputs request an access.
  assign stall  = busy_stall & ~reset;
  assign mem_we = mwmem & complete & ~misalign & ~reset;

  data_memory #(
    .ADDR_BITS(ADDR_BITS)
  ) u_data_memory (
    .clock(clock),
    .we   (mem_we),
    .addr (mr[ADDR_BITS+1:2]),
    .wdata(mqb),
    .rdata(rdata)
  );

  logic wexc_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wwreg    <= 1'b0;
      wm2reg   <= 1'b0;
      wdestReg <= '0;
      wr       <= '0;
      wdo      <= '0;
      wexc_reg <= 1'b0;
    end else if (complete) begin
      wwreg    <= mwreg & ~misalign;
      wm2reg   <= mm2reg;
      wdestReg <= mdestReg;
      wr       <= mr;
      wdo      <= rdata;
      wexc_reg <= misalign;
    end else begin
      // Bubble while the access is outstanding; data fields hold.
      wwreg    <= 1'b0;
      wm2reg   <= 1'b0;
      wexc_reg <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign wexc = wexc_reg;
`else
  logic unused_wexc;
  assign unused_wexc = wexc_reg;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: three instances (latency 0, 2, 3) share one input bus.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwreg, mm2reg, mwmem;
  logic [4:0]  mdestReg;
  logic [31:0] mr, mqb;

  logic [2:0]  stall_v, wwreg_v, wm2reg_v, wexc_v;
  logic [4:0]  wdest_v [3];
  logic [31:0] wr_v [3];
  logic [31:0] wdo_v [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  mem_wb_stage #(.ADDR_BITS(8), .MEM_LATENCY(0)) u_lat0 (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mdestReg(mdestReg), .mr(mr), .mqb(mqb), .stall(stall_v[0]), .wwreg(wwreg_v[0]),
    .wm2reg(wm2reg_v[0]), .wdestReg(wdest_v[0]), .wr(wr_v[0]),
`ifdef MEM_MISALIGN_TRAP_EN
    .wexc(wexc_v[0]),
`endif
    .wdo(wdo_v[0]));

  mem_wb_stage #(.ADDR_BITS(8), .MEM_LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mdestReg(mdestReg), .mr(mr), .mqb(mqb), .stall(stall_v[1]), .wwreg(wwreg_v[1]),
    .wm2reg(wm2reg_v[1]), .wdestReg(wdest_v[1]), .wr(wr_v[1]),
`ifdef MEM_MISALIGN_TRAP_EN
    .wexc(wexc_v[1]),
`endif
    .wdo(wdo_v[1]));

  mem_wb_stage #(.ADDR_BITS(8), .MEM_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mdestReg(mdestReg), .mr(mr), .mqb(mqb), .stall(stall_v[2]), .wwreg(wwreg_v[2]),
    .wm2reg(wm2reg_v[2]), .wdestReg(wdest_v[2]), .wr(wr_v[2]),
`ifdef MEM_MISALIGN_TRAP_EN
    .wexc(wexc_v[2]),
`endif
    .wdo(wdo_v[2]));

`ifndef MEM_MISALIGN_TRAP_EN
  assign wexc_v = 3'b000;
`endif

  typedef struct {
    int          sel;      // 0: latency 0, 1: latency 2, 2: latency 3
    logic        wreg;
    logic        m2;
    logic        wm;
    logic [4:0]  dest;
    logic [31:0] r;
    logic [31:0] q;
    int          exp_stalls;
    logic        exp_wwreg;
    logic        exp_wm2reg;
    logic [31:0] exp_wdo;
    logic        chk_wdo;
  } vec_t;

  function automatic vec_t mk(int sel, logic wreg, logic m2, logic wm, logic [4:0] dest,
                              logic [31:0] r, logic [31:0] q, int st, logic ew, logic em,
                              logic [31:0] edo, logic cd);
    vec_t v;
    v.sel = sel; v.wreg = wreg; v.m2 = m2; v.wm = wm; v.dest = dest; v.r = r; v.q = q;
    v.exp_stalls = st; v.exp_wwreg = ew; v.exp_wm2reg = em; v.exp_wdo = edo; v.chk_wdo = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_inputs(input logic wreg, input logic m2, input logic wm,
                            input logic [4:0] dest, input logic [31:0] r, input logic [31:0] q);
    mwreg = wreg; mm2reg = m2; mwmem = wm; mdestReg = dest; mr = r; mqb = q;
  endtask

  // Leaves the bench just after a rising edge with all DUTs idle.
  task automatic do_reset();
    set_inputs(0, 0, 0, 5'd0, 32'd0, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // Drives one instruction, holds it while the selected DUT stalls, returns just after the completing edge.
  task automatic issue(input int sel, input logic wreg, input logic m2, input logic wm,
                       input logic [4:0] dest, input logic [31:0] r, input logic [31:0] q,
                       output int nst);
    set_inputs(wreg, m2, wm, dest, r, q);
    nst = 0;
    while (1) begin
      @(negedge clock);
      if (!stall_v[sel]) break;
      nst++;
      if (nst > 20) begin
        total_cnt++;
        $display("FAIL stall_timeout: got more than 20 stall cycles, expected at most 15");
        break;
      end
      @(posedge clock); #1;
      chk("bubble_wwreg", 32'(wwreg_v[sel]), 32'd0);
    end
    @(posedge clock); #1;
  endtask

  vec_t vecs[13];

  initial begin
    int nst;
    reset = 1'b0;
    set_inputs(0, 0, 0, 5'd0, 32'd0, 32'd0);

    //                sel wr m2 wm dest  r             q             st ew em exp_wdo       chk
    vecs[0]  = mk(0, 0, 0, 1, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         0);
    vecs[1]  = mk(0, 1, 1, 0, 5'd5, 32'h0000_0010, 32'h0,         0, 1, 1, 32'hDEAD_BEEF, 1);
    vecs[2]  = mk(0, 0, 0, 1, 5'd0, 32'h0000_0400, 32'hCAFE_F00D, 0, 0, 0, 32'h0,         0);
    vecs[3]  = mk(0, 1, 1, 0, 5'd7, 32'h0000_0000, 32'h0,         0, 1, 1, 32'hCAFE_F00D, 1);
    vecs[4]  = mk(0, 1, 0, 0, 5'd3, 32'h0000_1234, 32'h0,         0, 1, 0, 32'h0,         0);
    vecs[5]  = mk(0, 1, 1, 1, 5'd8, 32'h0000_0010, 32'h1111_1111, 0, 1, 1, 32'hDEAD_BEEF, 1);
    vecs[6]  = mk(0, 1, 1, 0, 5'd8, 32'h0000_0010, 32'h0,         0, 1, 1, 32'h1111_1111, 1);
    vecs[7]  = mk(2, 0, 0, 1, 5'd0, 32'h0000_0040, 32'hAAAA_0001, 3, 0, 0, 32'h0,         0);
    vecs[8]  = mk(2, 1, 1, 0, 5'd9, 32'h0000_0040, 32'h0,         3, 1, 1, 32'hAAAA_0001, 1);
    vecs[9]  = mk(2, 1, 0, 0, 5'd4, 32'h0000_0055, 32'h0,         0, 1, 0, 32'h0,         0);
    vecs[10] = mk(1, 0, 0, 1, 5'd0, 32'h0000_0020, 32'h2020_2020, 2, 0, 0, 32'h0,         0);
    vecs[11] = mk(1, 0, 0, 1, 5'd0, 32'h0000_0024, 32'h2424_2424, 2, 0, 0, 32'h0,         0);
    vecs[12] = mk(1, 1, 1, 0, 5'd2, 32'h0000_0020, 32'h0,         2, 1, 1, 32'h2020_2020, 1);

    for (int i = 0; i < 13; i++) begin
      int s;
      s = vecs[i].sel;
      if (i == 0 || vecs[i].sel != vecs[i-1].sel) do_reset();
      issue(s, vecs[i].wreg, vecs[i].m2, vecs[i].wm, vecs[i].dest, vecs[i].r, vecs[i].q, nst);
      $display("vec %0d dut %0d: stalls %0d wwreg %0b wm2reg %0b dest %0d wr %h wdo %h",
               i, s, nst, wwreg_v[s], wm2reg_v[s], wdest_v[s], wr_v[s], wdo_v[s]);
      chk($sformatf("v%0d_stalls", i), 32'(nst), 32'(vecs[i].exp_stalls));
      chk($sformatf("v%0d_wwreg", i), 32'(wwreg_v[s]), 32'(vecs[i].exp_wwreg));
      chk($sformatf("v%0d_wm2reg", i), 32'(wm2reg_v[s]), 32'(vecs[i].exp_wm2reg));
      chk($sformatf("v%0d_wdest", i), 32'(wdest_v[s]), 32'(vecs[i].dest));
      chk($sformatf("v%0d_wr", i), wr_v[s], vecs[i].r);
      if (vecs[i].chk_wdo) chk($sformatf("v%0d_wdo", i), wdo_v[s], vecs[i].exp_wdo);
    end

    // Second word of the back-to-back pair.
    issue(1, 1, 1, 0, 5'd3, 32'h0000_0024, 32'h0, nst);
    $display("seq readback 0x24 dut 1: stalls %0d wdo %h", nst, wdo_v[1]);
    chk("b2b_rd24_stalls", 32'(nst), 32'd2);
    chk("b2b_rd24_wdo", wdo_v[1], 32'h2424_2424);

    // Asynchronous reset mid-cycle with an access request on the bus.
    set_inputs(1, 0, 0, 5'd5, 32'h0000_0080, 32'h0);
    @(posedge clock); #1;
    chk("pre_reset_wwreg", 32'(wwreg_v[0]), 32'd1);
    set_inputs(1, 1, 0, 5'd5, 32'h0000_0080, 32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    $display("seq async reset: stall %b wwreg %b wm2reg %b", stall_v, wwreg_v, wm2reg_v);
    chk("rst_stall", 32'(stall_v), 32'd0);
    chk("rst_wwreg", 32'(wwreg_v), 32'd0);
    chk("rst_wm2reg", 32'(wm2reg_v), 32'd0);
    chk("rst_wexc", 32'(wexc_v), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_wdest%0d", k), 32'(wdest_v[k]), 32'd0);
      chk($sformatf("rst_wr%0d", k), wr_v[k], 32'd0);
      chk($sformatf("rst_wdo%0d", k), wdo_v[k], 32'd0);
    end
    set_inputs(0, 0, 0, 5'd0, 32'd0, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Reset in the second stall cycle of a latency-3 store aborts the write.
    set_inputs(0, 0, 1, 5'd0, 32'h0000_0040, 32'hBBBB_BBBB);
    @(negedge clock);
    chk("abort_stall1", 32'(stall_v[2]), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("abort_stall2", 32'(stall_v[2]), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_stall_drop", 32'(stall_v[2]), 32'd0);
    set_inputs(0, 0, 0, 5'd0, 32'd0, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    issue(2, 1, 1, 0, 5'd9, 32'h0000_0040, 32'h0, nst);
    $display("seq abort readback dut 2: stalls %0d wdo %h", nst, wdo_v[2]);
    chk("abort_rd_stalls", 32'(nst), 32'd3);
    chk("abort_rd_wdo", wdo_v[2], 32'hAAAA_0001);

`ifdef MEM_MISALIGN_TRAP_EN
    issue(0, 0, 0, 1, 5'd0, 32'h0000_0013, 32'h9999_9999, nst);
    $display("seq misaligned store dut 0: wexc %b wwreg %b", wexc_v[0], wwreg_v[0]);
    chk("mis_st_wexc", 32'(wexc_v[0]), 32'd1);
    issue(0, 1, 1, 0, 5'd6, 32'h0000_0013, 32'h0, nst);
    $display("seq misaligned load dut 0: wexc %b wwreg %b", wexc_v[0], wwreg_v[0]);
    chk("mis_ld_wexc", 32'(wexc_v[0]), 32'd1);
    chk("mis_ld_wwreg", 32'(wwreg_v[0]), 32'd0);
    issue(0, 1, 1, 0, 5'd6, 32'h0000_0010, 32'h0, nst);
    $display("seq aligned readback dut 0: wexc %b wdo %h", wexc_v[0], wdo_v[0]);
    chk("mis_rd_wexc", 32'(wexc_v[0]), 32'd0);
    chk("mis_rd_wwreg", 32'(wwreg_v[0]), 32'd1);
    chk("mis_rd_wdo", wdo_v[0], 32'h1111_1111);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
